router_fifo: RTL and testbench

- Per-port output buffer of the router, three instances, one per destination port.
- Sits directly downstream of the synchronizer, which supplies the one-hot write enable and the per-port soft reset and consumes full/empty.
- Stores 8-bit packet bytes tagged with a header flag.
- Tracks the remaining bytes of the packet being read out, so the read side knows where a packet ends.

---
 rtl/router_fifo.sv | 63 ++++++
 tb/tb_router_fifo.sv | 131 +++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer storing header-tagged bytes and tracking the remaining bytes of the packet being read.
// Optional ROUTER_FIFO_TRISTATE_EN makes data_out float instead of driving 0 when cleared or idle.
module router_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  soft_reset,
   input  logic                  write_enb,
   input  logic                  read_enb,
   input  logic                  lfd_state,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty
);
`ifdef ROUTER_FIFO_TRISTATE_EN
   localparam logic [DATA_WIDTH-1:0] IDLE_VAL = 'z;
`else
   localparam logic [DATA_WIDTH-1:0] IDLE_VAL = '0;
`endif
   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [6:0]            pkt_count_q, pkt_count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [DATA_WIDTH:0]   rd_word;
   logic                  do_wr, do_rd, clr;
   assign empty    = wr_ptr_q == rd_ptr_q;
   assign full     = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign clr      = !resetn || soft_reset;
   assign do_wr    = write_enb && !full;
   assign do_rd    = read_enb && !empty;
   assign rd_word  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
   assign data_out = data_out_q;
   // A header word loads its payload length plus one for the trailing parity byte
   always_comb begin
      wr_ptr_d    = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      pkt_count_d = !do_rd ? pkt_count_q :
                    rd_word[DATA_WIDTH] ? 7'(rd_word[DATA_WIDTH-1:2]) + 7'd1 :
                    (pkt_count_q != 7'd0) ? pkt_count_q - 7'd1 : pkt_count_q;
      data_out_d  = do_rd ? rd_word[DATA_WIDTH-1:0] :
                    (pkt_count_q == 7'd0) ? IDLE_VAL : data_out_q;
   end
   always_ff @(posedge clock) begin
      if (clr) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pkt_count_q <= '0;
         data_out_q  <= IDLE_VAL;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pkt_count_q <= pkt_count_d;
         data_out_q  <= data_out_d;
         if (do_wr) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};
      end
   end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed stimulus against a queue-based model of router_fifo, checked every cycle on the falling edge.
module tb_router_fifo;
`ifdef ROUTER_FIFO_TRISTATE_EN
   localparam logic [7:0] IDLE = 'z;
`else
   localparam logic [7:0] IDLE = '0;
`endif
   logic       clock = 0, resetn = 0, soft_reset = 0, write_enb = 0, read_enb = 0, lfd_state = 0;
   logic [7:0] data_in = 0, data_out;
   logic       full, empty;
   int         checks = 0, errors = 0;
   bit         chk_en = 0;
   logic [8:0] q[$];
   int         m_pkt = 0;
   logic [7:0] m_dout = 0;

   router_fifo dut (
      .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
      .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
      .data_out(data_out), .full(full), .empty(empty)
   );

   always #5 clock = ~clock;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   // Model: FIFO is a queue; occupancy decides full/empty
   always @(posedge clock) begin
      logic [8:0] w;
      if (!resetn || soft_reset) begin
         q.delete();
         m_pkt  = 0;
         m_dout = IDLE;
      end else begin
         bit rd_ok, wr_ok;
         rd_ok = read_enb && q.size() != 0;
         wr_ok = write_enb && q.size() != 16;
         if (rd_ok) begin
            w = q.pop_front();
            m_dout = w[7:0];
            if (w[8]) m_pkt = int'(w[7:2]) + 1;
            else if (m_pkt != 0) m_pkt--;
         end else if (m_pkt == 0) m_dout = IDLE;
         if (wr_ok) q.push_back({lfd_state, data_in});
      end
   end

   always @(negedge clock) if (chk_en) begin
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 16));
      chk("data_out", 32'(data_out), 32'(m_dout));
   end

   task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] d);
      write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
      @(negedge clock);
   endtask

   initial begin
      logic [7:0] hb [5];
      int         hp [5];
      hb = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
      hp = '{4, 3, 2, 1, 0};
      @(negedge clock);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      resetn = 1;
      chk_en = 1;
      repeat (3) step(0, 0, 0, 0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_dout", 32'(data_out), 32'(IDLE));
      // header packet: 0x0C carries length 3, counter starts at 4
      for (int i = 0; i < 5; i++) step(1, 0, i == 0, hb[i]);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0);
         chk("pkt_byte", 32'(data_out), 32'(hb[i]));
         chk("pkt_cnt", 32'(m_pkt), 32'(hp[i]));
      end
      step(0, 0, 0, 0);
      chk("pkt_idle", 32'(data_out), 32'(IDLE));
      for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h50 + 8'(i));
      chk("fill_full", 32'(full), 32'd1);
      step(1, 0, 0, 8'hFF);
      chk("drop_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0, 0);
         chk("drain_byte", 32'(data_out), 32'(8'h50 + 8'(i)));
      end
      chk("drain_empty", 32'(empty), 32'd1);
      step(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h60 + 8'(i));
      step(1, 1, 0, 8'hAA);
      chk("rw_full", 32'(full), 32'd0);
      chk("rw_byte", 32'(data_out), 32'h60);
      chk("rw_occ", 32'(q.size()), 32'd15);
      for (int i = 1; i < 16; i++) begin
         step(0, 1, 0, 0);
         chk("rw_drain", 32'(data_out), 32'(8'h60 + 8'(i)));
      end
      chk("rw_empty", 32'(empty), 32'd1);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 8'h70 + 8'(i));
      soft_reset = 1;
      step(1, 0, 0, 8'hBB);
      soft_reset = 0;
      chk("sr_empty", 32'(empty), 32'd1);
      chk("sr_dout", 32'(data_out), 32'(IDLE));
      step(1, 0, 0, 8'h01);
      step(0, 1, 0, 0);
      chk("sr_readback", 32'(data_out), 32'h01);
      chk("sr_after", 32'(empty), 32'd1);
      step(1, 0, 0, 8'h80);
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 0, 8'(i));
         chk("wrap_byte", 32'(data_out), i == 0 ? 32'h80 : 32'(i - 1));
      end
      step(0, 1, 0, 0);
      chk("wrap_last", 32'(data_out), 32'd39);
      chk("wrap_empty", 32'(empty), 32'd1);
      step(0, 0, 0, 0);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
